// File: rtl/spcpu_bus_ctrl.sv
// spcpu_bus_ctrl: bus interface between the spcpu data port and a byte-wide
// synchronous memory. One 8/16-bit request at a time is split into one or two
// byte phases of WAIT_STATES+1 cycles each. Read data is assembled big-endian,
// so the byte at the lower address becomes the high byte.
module spcpu_bus_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic                  cpu_acc_sz,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [15:0]           cpu_wdata,
  output logic [15:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BYTE0,
    BYTE1,
    DONE
  } state_t;

  // Wait-state count is a 4-bit field; each phase lasts r_cnt+1 cycles.
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  state_t                  r_state;
  state_t                  w_nextState;
  logic                    r_we;
  logic                    r_sz;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [15:0]             r_wdata;
  logic [3:0]              r_cnt;
  logic [7:0]              r_hiByte;
  logic [15:0]             r_rdata;
  logic                    w_accept;
  logic                    w_lastCycle;
  logic                    w_inPhase;
  logic                    w_enterPhase;

  assign w_accept     = (r_state == IDLE) && cpu_req;
  assign w_lastCycle  = (r_cnt == 4'd0);
  assign w_inPhase    = (r_state == BYTE0) || (r_state == BYTE1);
  assign w_enterPhase = w_accept || ((r_state == BYTE0) && w_lastCycle && r_sz);
  assign cpu_rdata    = r_rdata;

  // State register; reset aborts any transfer and returns to IDLE at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode; all memory strobes derive from the state
  // so that reset removes mem_we without waiting for a clock.
  always_comb begin
    w_nextState = r_state;
    cpu_ready   = 1'b0;
    busy        = 1'b1;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (cpu_req) begin
          w_nextState = BYTE0;
        end
      end
      BYTE0: begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_sz ? r_wdata[15:8] : r_wdata[7:0];
        if (w_lastCycle) begin
          w_nextState = r_sz ? BYTE1 : DONE;
        end
      end
      BYTE1: begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr + ADDR_WIDTH'(1);
        mem_wdata = r_wdata[7:0];
        if (w_lastCycle) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        cpu_ready   = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Latch the request on acceptance so later CPU-side changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_sz    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= cpu_we;
      r_sz    <= cpu_acc_sz;
      r_addr  <= cpu_addr;
      r_wdata <= cpu_wdata;
    end
  end

  // Wait-state down-counter, reloaded at the start of every byte phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_enterPhase) begin
      r_cnt <= WS_LOAD;
    end else if (w_inPhase && !w_lastCycle) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Capture read bytes on each phase's closing edge; the high byte is staged
  // so cpu_rdata only changes when the whole read has completed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hiByte <= '0;
      r_rdata  <= '0;
    end else if (w_inPhase && w_lastCycle && !r_we) begin
      if (r_state == BYTE1) begin
        r_rdata <= {r_hiByte, mem_rdata};
      end else if (r_sz) begin
        r_hiByte <= mem_rdata;
      end else begin
        r_rdata <= {8'h00, mem_rdata};
      end
    end
  end

endmodule

// File: tb/tb_spcpu_bus_ctrl.sv
// Testbench for spcpu_bus_ctrl. Two instances run side by side, one with no
// wait states and one with two, each attached to its own byte memory that
// only presents valid read data in the last cycle of a phase and only
// commits writes on the edge that closes a phase.
module tb_spcpu_bus_ctrl;

  localparam int NDUT = 2;

  logic        clk = 1'b0;
  logic        resetN   [NDUT];
  logic        cpuReq   [NDUT];
  logic        cpuWe    [NDUT];
  logic        cpuAccSz [NDUT];
  logic [15:0] cpuAddr  [NDUT];
  logic [15:0] cpuWdata [NDUT];
  logic [15:0] cpuRdata [NDUT];
  logic        cpuReady [NDUT];
  logic        busy     [NDUT];
  logic        memEn    [NDUT];
  logic        memWe    [NDUT];
  logic [15:0] memAddr  [NDUT];
  logic [7:0]  memWdata [NDUT];
  logic [7:0]  memRdata [NDUT];

  int checks = 0;
  int errors = 0;

  logic [7:0]  benchMem [NDUT][65536];
  logic [7:0]  modelMem [NDUT][65536];
  logic [15:0] lastRd   [NDUT];

  bit          memReady = 1'b0;
  bit          pokeEn   = 1'b0;
  logic [15:0] pokeAddr = 16'h0000;
  logic [7:0]  pokeVal  = 8'h00;
  int          phaseCnt [NDUT] = '{default: 0};
  logic        prevEn   [NDUT] = '{default: 1'b0};
  logic [15:0] prevAddr [NDUT] = '{default: 16'h0000};

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic int wsOf(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic [7:0] initByte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Device instances: index 0 has no wait states, index 1 has two.
  for (genvar g = 0; g < NDUT; g++) begin : gDut
    spcpu_bus_ctrl #(
      .ADDR_WIDTH (16),
      .WAIT_STATES(g == 0 ? 0 : 2)
    ) u_dut (
      .clk       (clk),
      .reset     (resetN[g]),
      .cpu_req   (cpuReq[g]),
      .cpu_we    (cpuWe[g]),
      .cpu_acc_sz(cpuAccSz[g]),
      .cpu_addr  (cpuAddr[g]),
      .cpu_wdata (cpuWdata[g]),
      .cpu_rdata (cpuRdata[g]),
      .cpu_ready (cpuReady[g]),
      .busy      (busy[g]),
      .mem_en    (memEn[g]),
      .mem_we    (memWe[g]),
      .mem_addr  (memAddr[g]),
      .mem_wdata (memWdata[g]),
      .mem_rdata (memRdata[g])
    );
  end

  // Track how many cycles the current phase has lasted (a phase is a run of
  // enabled cycles at one address).
  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (memEn[g] === 1'b1 && prevEn[g] === 1'b1 && memAddr[g] == prevAddr[g]) begin
        phaseCnt[g] <= phaseCnt[g] + 1;
      end else begin
        phaseCnt[g] <= 0;
      end
      prevEn[g]   <= memEn[g];
      prevAddr[g] <= memAddr[g];
    end
  end

  // Memory read port: data is only correct in the final cycle of a phase.
  always_comb begin
    for (int g = 0; g < NDUT; g++) begin
      memRdata[g] = (phaseCnt[g] == wsOf(g)) ? benchMem[g][memAddr[g]] : ~benchMem[g][memAddr[g]];
    end
  end

  // Memory array: one-time fill, bench pokes, and writes committed on the
  // edge closing a full-length write phase.
  always @(posedge clk) begin
    if (!memReady) begin
      for (int a = 0; a < 65536; a++) begin
        for (int g = 0; g < NDUT; g++) begin
          benchMem[g][a] <= initByte(16'(a));
        end
      end
      memReady <= 1'b1;
    end
    if (pokeEn) begin
      for (int g = 0; g < NDUT; g++) begin
        benchMem[g][pokeAddr] <= pokeVal;
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      if (memEn[g] === 1'b1 && memWe[g] === 1'b1 && phaseCnt[g] == wsOf(g)) begin
        benchMem[g][memAddr[g]] <= memWdata[g];
      end
    end
  end

  task automatic checkOutput(input int d, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic pokeByte(input logic [15:0] a, input logic [7:0] v);
    for (int g = 0; g < NDUT; g++) begin
      modelMem[g][a] = v;
    end
    @(negedge clk);
    pokeAddr = a;
    pokeVal  = v;
    pokeEn   = 1'b1;
    @(negedge clk);
    pokeEn   = 1'b0;
  endtask

  // mode 0: plain request; 1: cpu_req held through DONE (back-to-back);
  // 2: reset during the second byte of a 16-bit write;
  // 3: CPU inputs scrambled after acceptance plus a stray request while busy.
  task automatic applyStimulus(input int d, input logic we, input logic sz,
                               input logic [15:0] addr, input logic [15:0] wdata, input int mode);
    int          ws, nBytes, expLat, win, readyCyc, pulses, enCycles;
    int          badBusy, badRdy, badRd, expPulses;
    logic [15:0] a1, prevRd, expRdNow;
    bit          expB, expR, hit;
    ws     = wsOf(d);
    nBytes = sz ? 2 : 1;
    expLat = nBytes * (ws + 1) + 1;
    a1     = addr + 16'd1;
    prevRd = lastRd[d];
    if (mode == 2) begin
      modelMem[d][addr] = wdata[15:8];
    end else if (we) begin
      if (sz) begin
        modelMem[d][addr] = wdata[15:8];
        modelMem[d][a1]   = wdata[7:0];
      end else begin
        modelMem[d][addr] = wdata[7:0];
      end
    end else begin
      lastRd[d] = sz ? {modelMem[d][addr], modelMem[d][a1]} : {8'h00, modelMem[d][addr]};
    end

    @(negedge clk);
    cpuReq[d]   = 1'b1;
    cpuWe[d]    = we;
    cpuAccSz[d] = sz;
    cpuAddr[d]  = addr;
    cpuWdata[d] = wdata;

    if (mode == 2) begin
      hit = 1'b0;
      for (int c = 1; c <= 20 && !hit; c++) begin
        @(negedge clk);
        cpuReq[d] = 1'b0;
        if (memEn[d] === 1'b1 && memAddr[d] == a1) begin
          hit = 1'b1;
          resetN[d] = 1'b0;
          #1;
          checkOutput(d, "rstMemWe", 64'(memWe[d]), 64'd0);
          checkOutput(d, "rstOutputs", 64'({cpuRdata[d], cpuReady[d], busy[d], memEn[d],
                                            memWe[d], memAddr[d], memWdata[d]}), 64'd0);
        end
      end
      checkOutput(d, "rstHitByte1", 64'(hit), 64'd1);
      resetN[d] = 1'b0;
      repeat (2) @(negedge clk);
      resetN[d] = 1'b1;
      lastRd[d] = 16'h0000;
      @(negedge clk);
      checkOutput(d, "rstIdle", 64'(busy[d]), 64'd0);
      checkOutput(d, "rstHiCommitted", 64'(benchMem[d][addr]), 64'(modelMem[d][addr]));
      checkOutput(d, "rstLoNotWritten", 64'(benchMem[d][a1]), 64'(modelMem[d][a1]));
      return;
    end

    win       = (mode == 1) ? 2 * expLat + 3 : expLat + 3;
    expPulses = (mode == 1) ? 2 : 1;
    readyCyc  = 0;
    pulses    = 0;
    enCycles  = 0;
    badBusy   = 0;
    badRdy    = 0;
    badRd     = 0;
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      expB     = (c <= expLat) || (mode == 1 && c >= expLat + 2 && c <= 2 * expLat + 1);
      expR     = (c == expLat) || (mode == 1 && c == 2 * expLat + 1);
      expRdNow = (c < expLat) ? prevRd : lastRd[d];
      if (busy[d] !== expB) badBusy++;
      if (cpuReady[d] !== expR) badRdy++;
      if (cpuRdata[d] !== expRdNow) badRd++;
      if (memEn[d] === 1'b1) enCycles++;
      if (cpuReady[d] === 1'b1) begin
        pulses++;
        if (readyCyc == 0) readyCyc = c;
      end
      if (c == 1 && mode != 1) cpuReq[d] = 1'b0;
      if (c == 1 && mode == 3) begin
        cpuWe[d]    = ~we;
        cpuAccSz[d] = ~sz;
        cpuAddr[d]  = 16'($urandom);
        cpuWdata[d] = 16'($urandom);
      end
      if (mode == 3 && c == 2) cpuReq[d] = 1'b1;
      if (mode == 3 && c == 3) cpuReq[d] = 1'b0;
      if (mode == 1 && c == expLat + 2) cpuReq[d] = 1'b0;
    end
    checkOutput(d, "readyLatency", 64'(readyCyc), 64'(expLat));
    checkOutput(d, "readyPulses", 64'(pulses), 64'(expPulses));
    checkOutput(d, "readyTrace", 64'(badRdy), 64'd0);
    checkOutput(d, "busyTrace", 64'(badBusy), 64'd0);
    checkOutput(d, "memEnCycles", 64'(enCycles), 64'(expPulses * nBytes * (ws + 1)));
    checkOutput(d, "rdataTrace", 64'(badRd), 64'd0);
    if (we) begin
      checkOutput(d, "memByteA", 64'(benchMem[d][addr]), 64'(modelMem[d][addr]));
      checkOutput(d, "memByteA1", 64'(benchMem[d][a1]), 64'(modelMem[d][a1]));
    end
  endtask

  task automatic runBoth(input logic we, input logic sz, input logic [15:0] addr,
                         input logic [15:0] wdata, input int mode);
    fork
      applyStimulus(0, we, sz, addr, wdata, mode);
      applyStimulus(1, we, sz, addr, wdata, mode);
    join
  endtask

  // Safety net in case the simulation stops making progress.
  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [15:0] ra;
    logic [15:0] rw;
    logic        rwe;
    logic        rsz;
    int          rm;

    for (int g = 0; g < NDUT; g++) begin
      resetN[g]   = 1'b0;
      cpuReq[g]   = 1'b0;
      cpuWe[g]    = 1'b0;
      cpuAccSz[g] = 1'b0;
      cpuAddr[g]  = 16'h0000;
      cpuWdata[g] = 16'h0000;
      lastRd[g]   = 16'h0000;
    end
    for (int a = 0; a < 65536; a++) begin
      for (int g = 0; g < NDUT; g++) begin
        modelMem[g][a] = initByte(16'(a));
      end
    end

    repeat (3) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput(g, "resetOutputs", 64'({cpuRdata[g], cpuReady[g], busy[g], memEn[g],
                                          memWe[g], memAddr[g], memWdata[g]}), 64'd0);
      resetN[g] = 1'b1;
    end
    @(negedge clk);

    $display("[TB] 8-bit read at 0010");
    pokeByte(16'h0010, 8'hA5);
    runBoth(1'b0, 1'b0, 16'h0010, 16'h0000, 0);
    for (int g = 0; g < NDUT; g++) checkOutput(g, "rd8A5", 64'(cpuRdata[g]), 64'h00A5);

    $display("[TB] 16-bit write BEEF at 0020");
    runBoth(1'b1, 1'b1, 16'h0020, 16'hBEEF, 0);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput(g, "wrBE", 64'(benchMem[g][16'h0020]), 64'hBE);
      checkOutput(g, "wrEF", 64'(benchMem[g][16'h0021]), 64'hEF);
    end

    $display("[TB] 16-bit read wrapping at FFFF");
    pokeByte(16'hFFFF, 8'h12);
    pokeByte(16'h0000, 8'h34);
    runBoth(1'b0, 1'b1, 16'hFFFF, 16'h0000, 0);
    for (int g = 0; g < NDUT; g++) checkOutput(g, "rdWrap", 64'(cpuRdata[g]), 64'h1234);

    $display("[TB] input scrambling and stray request while busy");
    runBoth(1'b1, 1'b1, 16'h0040, 16'hCAFE, 3);
    runBoth(1'b0, 1'b0, 16'h0040, 16'h0000, 3);
    for (int g = 0; g < NDUT; g++) checkOutput(g, "rdLatched", 64'(cpuRdata[g]), 64'h00CA);

    $display("[TB] back-to-back request with cpu_req held");
    runBoth(1'b0, 1'b1, 16'h0041, 16'h0000, 1);
    for (int g = 0; g < NDUT; g++) checkOutput(g, "rdOddAddr", 64'(cpuRdata[g]), 64'hFE00 | 64'(modelMem[g][16'h0042]));

    $display("[TB] reset during second byte of a write");
    runBoth(1'b1, 1'b1, 16'h0050, 16'h1357, 2);
    runBoth(1'b0, 1'b0, 16'h0050, 16'h0000, 0);
    for (int g = 0; g < NDUT; g++) checkOutput(g, "rdAfterRst", 64'(cpuRdata[g]), 64'h0013);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 24; i++) begin
      ra  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 255));
      rw  = 16'($urandom);
      rwe = 1'($urandom_range(0, 1));
      rsz = 1'($urandom_range(0, 1));
      rm  = $urandom_range(0, 2);
      if (rm == 2) rm = 3;
      runBoth(rwe, rsz, ra, rw, rm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
